// File: rtl/regfile_mp_if.sv
// Issue/read/writeback bundle for the multi-port register file.
// The master side is the pipeline (decode/issue and writeback); the slave side is the register file.
interface regfile_mp_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2
);
    localparam int AW = $clog2(NREG);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NWR-1:0]      wr_clr;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic [AW:0]         busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, wr_clr, iss_en, iss_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard and a registered busy count.
// Define RF_BYPASS_EN to forward same-cycle writes (data and busy clear) onto the read ports.
module regfile_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2,
    parameter int NWR  = 2,
    localparam int AW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    regfile_mp_if.slave   bus
);
    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] clr_vec;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] busy_next;
    logic            cnt_inc;
    logic [AW:0]     cnt_dec;
    logic [AW:0]     cnt;

    function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
        logic [AW:0] c;
        c = '0;
        for (int k = 0; k < NREG; k++) begin
            c = c + {{AW{1'b0}}, v[k]};
        end
        return c;
    endfunction

    // Returns {busy, data} for one read port.
    function automatic logic [XLEN:0] read_port(input logic [AW-1:0] ra);
        logic [XLEN-1:0] d;
        logic            b;
        d = regs[ra];
        b = busy[ra];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] == ra) begin
                d = bus.wr_data[w*XLEN +: XLEN];
                b = (bus.wr_clr[w] && !(bus.iss_en && bus.iss_addr == ra)) ? 1'b0 : busy[ra];
            end
        end
`endif
        if (!rst_n || ra == '0) begin
            d = '0;
            b = 1'b0;
        end
        return {b, d};
    endfunction

    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            {bus.rd_busy[i], bus.rd_data[i*XLEN +: XLEN]} = read_port(bus.rd_addr[i*AW +: AW]);
        end
    end

    // Set dominates clear: a fresh producer supersedes the one being retired.
    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int w = 0; w < NWR; w++) begin
            if (bus.wr_en[w] && bus.wr_clr[w]) begin
                clr_vec[bus.wr_addr[w*AW +: AW]] = 1'b1;
            end
        end
        if (bus.iss_en) begin
            set_vec[bus.iss_addr] = 1'b1;
        end
        clr_vec[0] = 1'b0;
        set_vec[0] = 1'b0;
        busy_next  = (busy & ~clr_vec) | set_vec;
    end

    assign cnt_inc = |(set_vec & ~busy);
    assign cnt_dec = popcount(clr_vec & busy & ~set_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int w = 0; w < NWR; w++) begin
                if (bus.wr_en[w] && bus.wr_addr[w*AW +: AW] != '0) begin
                    regs[bus.wr_addr[w*AW +: AW]] <= bus.wr_data[w*XLEN +: XLEN];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            cnt  <= '0;
        end else begin
            busy <= busy_next;
            cnt  <= cnt + {{AW{1'b0}}, cnt_inc} - cnt_dec;
        end
    end

    assign bus.busy_cnt = cnt;
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-port integer register file for the next-generation pipeline, supporting dual-issue and multiple writeback.
- NRD combinational read ports and NWR write ports.
- Per-register scoreboard (busy bits): issue sets an entry, writeback clears it.
- Optional write-to-read bypass.
- Sits between decode/issue (reads, busy checks, busy set) and writeback (writes, busy clear).

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of 2, >=2)
NRD, 2, number of read ports
NWR, 2, number of write ports
AW, $clog2(NREG), register address width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
rd_addr  input  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  output  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  output  NRD  1 = addressed register has an outstanding producer
wr_en  input  NWR  write enables per port
wr_addr  input  NWR*AW  write addresses
wr_data  input  NWR*XLEN  write data
wr_clr  input  NWR  1 = this write also clears the busy bit of wr_addr
iss_en  input  1  mark iss_addr busy at next edge
iss_addr  input  AW  register being allocated as a destination
busy_cnt  output  AW+1  number of registers currently busy (registered)

Behaviour:
- Reset (async, rst_n low): all registers 0, all busy bits 0, busy_cnt 0.
  - rd_data reads 0 for every address and rd_busy is 0 while reset is held.
  - Reset may assert mid-operation; pending writes and issues that cycle are discarded.
- Register 0 is hardwired zero:
  - Writes to addr 0 are ignored.
  - iss_en to addr 0 is ignored.
  - Reads of addr 0 return 0 with rd_busy 0, regardless of bypass.
- Writes take effect at the rising clk edge; read ports are combinational from the array, with zero-cycle latency.
- Write conflict: several ports writing the same non-zero addr in one cycle means the highest-index port wins. Same priority applies to bypass selection.
- Busy bits are updated at each clk edge:
  - A bit is cleared when any port has wr_en=1, wr_clr=1 and wr_addr equal to that register.
  - A bit is set when iss_en=1 and iss_addr equals that register.
  - Set and clear on the same addr in the same cycle: set wins, because the new producer supersedes the old one. The final bit is 1.
  - wr_en=1 with wr_clr=0 writes data but leaves the busy bit unchanged.
  - Clearing an idle register is a no-op.
  - Setting an already-busy register is a no-op; no count is kept per register.
- busy_cnt equals the population count of the busy bits.
  - Maintained incrementally: +1 on a 0->1 transition, -1 on a 1->0 transition.
  - Both transitions on different addrs in one cycle give net 0.
  - Never exceeds NREG-1.
- wr_clr is ignored when wr_en=0.

Optional Feature:
RF_BYPASS_EN
- Defined: a read port whose non-zero rd_addr matches any active write port this cycle returns that port's wr_data (highest index wins) in the same cycle.
  - rd_busy is reported 0 for that port if the matching write has wr_clr=1 and no same-cycle iss_en targets that addr.
- Undefined: reads return the pre-edge array contents and rd_busy reflects the registered busy bits only; the pipeline stalls one extra cycle on such hazards.

Test Plan:
- Reset, then write x5=0xDEADBEEF on port 0 and read x5 on both ports next cycle -> 0xDEADBEEF on both. Write to x0=0x1234 -> x0 reads 0.
- Same cycle, port0 writes x7=0x11 and port1 writes x7=0x22 -> x7 reads 0x22.
- iss_en x3, then a write to x3 with wr_clr=1 three cycles later:
  - rd_busy for x3 reads 1 for 3 cycles, then 0.
  - busy_cnt goes 0 -> 1 -> 0.
  - iss_en x0 leaves busy_cnt 0.
- Same cycle iss_en x9 and clearing write to x9 (x9 already busy) -> x9 stays busy, busy_cnt unchanged. Clearing x4 while setting x6 -> busy_cnt net unchanged.
- With RF_BYPASS_EN, write x10=0xA5A5A5A5 with wr_clr=1 while reading x10 -> rd_data 0xA5A5A5A5 and rd_busy 0 in the same cycle. Without it -> old value and rd_busy 1 that cycle.
- Assert rst_n low mid-stream with x1..x4 written and busy -> all reads 0, rd_busy 0, busy_cnt 0 immediately, without waiting for a clock edge.
